// File: rtl/im_loader.sv
// ----------------------------------------------------------------------------
// im_loader
//
// Receives a byte stream from a serial receiver and writes it into the
// instruction memory. A session is opened with a one-cycle start pulse.
// The stream format is:
//   - 4 bytes: word count N (big-endian)
//   - N x 4 bytes: instruction words (big-endian). Word k goes to byte
//     address BASE_ADDR + 4*k.
//   - 4 bytes: checksum, only when IM_LOADER_CKSUM_EN is defined. It must
//     equal the modulo-2^32 sum of the N words.
// The session ends in DONE (done=1) or ERR (err=1). Both flags stay set
// until the next start or reset.
//
// Optional feature macro: IM_LOADER_CKSUM_EN
//   defined   -> CKSUM state and running-sum logic are built
//   undefined -> writing the last word goes straight to DONE
//
// Parameters
//   BASE_ADDR  byte address of instruction word 0
//   MAX_WORDS  largest accepted word count
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset
//   start     one-cycle pulse that opens a session (honoured only when idle,
//             done or errored)
//   in_data   byte from the serial receiver
//   in_valid  in_data is valid this cycle
//   in_ready  loader accepts a byte (transfer = in_valid & in_ready)
//   we        instruction-memory write strobe, one cycle per word
//   waddr     byte address of the word being written (held between writes)
//   wdata     assembled instruction word (held between writes)
//   busy      session in progress (same as in_ready)
//   done      session completed without error, sticky
//   err       session aborted, sticky
// ----------------------------------------------------------------------------
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The index must be able to hold MAX_WORDS itself, because it is
    // incremented once more after the final word.
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

`ifdef IM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CKSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_cnt;
    logic [23:0]       partial;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  word_len;
    logic [31:0]       cur_word;
    logic              byte_last;
    logic              len_bad;
    logic              last_word;
    logic              start_ok;
`ifdef IM_LOADER_CKSUM_EN
    logic [31:0]       sum;
`endif

    // The word completed by the current byte. The first three bytes are held
    // in 'partial', and the incoming byte becomes bits [7:0]. This gives
    // big-endian ordering.
    assign cur_word  = {partial, in_data};
    // in_ready is omitted here on purpose. Every state that uses byte_last
    // already has in_ready=1. Leaving it out avoids a loop through the
    // output decode.
    assign byte_last = in_valid && (byte_cnt == 2'd3);
    assign len_bad   = (cur_word == 32'd0) || (cur_word > 32'(MAX_WORDS));
    assign last_word = (word_idx == word_len - IDX_W'(1));
    assign busy      = in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs. done/err are sticky
    // simply because DONE/ERR are held until the next start.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        start_ok  = 1'b0;
        unique case (state)
            IDLE, DONE, ERR: begin
                done = (state == DONE);
                err  = (state == ERR);
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = LEN;
                end
            end
            LEN: begin
                in_ready = 1'b1;
                if (byte_last) begin
                    state_nxt = len_bad ? ERR : DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (byte_last && last_word) begin
`ifdef IM_LOADER_CKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef IM_LOADER_CKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (byte_last) begin
                    state_nxt = (cur_word == sum) ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: byte assembly, word count capture, memory write and running
    // sum. A write is registered, so we/waddr/wdata appear in the cycle after
    // the fourth byte of a word. waddr/wdata are not cleared by start; they
    // keep the last written word until the next write.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
            word_idx <= '0;
            word_len <= '0;
            we       <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
`ifdef IM_LOADER_CKSUM_EN
            sum      <= 32'd0;
`endif
        end else begin
            we <= 1'b0;
            if (start_ok) begin
                byte_cnt <= 2'd0;
                partial  <= 24'd0;
                word_idx <= '0;
                word_len <= '0;
`ifdef IM_LOADER_CKSUM_EN
                sum      <= 32'd0;
`endif
            end else if (in_valid && in_ready) begin
                byte_cnt <= byte_cnt + 2'd1;
                partial  <= cur_word[23:0];
                if (byte_cnt == 2'd3) begin
                    if (state == LEN) begin
                        // An out-of-range count is truncated here. That is
                        // harmless because the FSM moves to ERR anyway.
                        word_len <= cur_word[IDX_W-1:0];
                    end
                    if (state == DATA) begin
                        we       <= 1'b1;
                        waddr    <= BASE_ADDR + 32'({word_idx, 2'b00});
                        wdata    <= cur_word;
                        word_idx <= word_idx + IDX_W'(1);
`ifdef IM_LOADER_CKSUM_EN
                        sum      <= sum + cur_word;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
`timescale 1ns/1ps
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int          MAXW = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Stimulus byte stream, expected writes {addr,data}, captured writes.
    logic [7:0]  stimBytes[$];
    logic [63:0] expQ[$];
    logic [63:0] capQ[$];
    logic        expDone;
    logic        expErr;

    always #5 clk = ~clk;

    im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Write monitor: record every memory write away from the active edge.
    always @(negedge clk) begin
        if (we === 1'b1) capQ.push_back({waddr, wdata});
    end

    // Safety net so the run can never hang.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        stimBytes.push_back(w[31:24]);
        stimBytes.push_back(w[23:16]);
        stimBytes.push_back(w[15:8]);
        stimBytes.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] wordAt(input int i);
        return {stimBytes[i], stimBytes[i+1], stimBytes[i+2], stimBytes[i+3]};
    endfunction

    // Reference model: read the stream the way the protocol defines it.
    task automatic buildExpected();
        logic [31:0] n;
        logic [31:0] s;
        logic [31:0] w;
        expQ.delete();
        expDone = 1'b0;
        expErr  = 1'b0;
        s = 32'd0;
        n = wordAt(0);
        if (n == 32'd0 || n > 32'(MAXW)) begin
            expErr = 1'b1;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            w = wordAt(4 + 4 * k);
            expQ.push_back({BASE + 32'(k) * 32'd4, w});
            s = s + w;
        end
`ifdef IM_LOADER_CKSUM_EN
        if (wordAt(4 + 4 * int'(n)) == s) expDone = 1'b1;
        else                              expErr  = 1'b1;
`else
        expDone = 1'b1;
`endif
    endtask

    // Random stream of n words. The sum is returned so that the caller can
    // append a checksum, either good or corrupted.
    task automatic buildStream(input logic [31:0] n, output logic [31:0] s);
        logic [31:0] w;
        s = 32'd0;
        stimBytes.delete();
        pushWord(n);
        if (n == 32'd0 || n > 32'(MAXW)) return;
        for (int k = 0; k < int'(n); k++) begin
            w = $urandom;
            pushWord(w);
            s = s + w;
        end
    endtask

    task automatic buildDirected();
        stimBytes.delete();
        pushWord(32'h0000_0002);
        pushWord(32'h2408_0001);
        pushWord(32'h2409_0002);
`ifdef IM_LOADER_CKSUM_EN
        pushWord(32'h4811_0003);
`endif
    endtask

    // Open a session and drive stimBytes. gapMode: 0 = back-to-back,
    // 1 = one idle cycle before every byte, 2 = random 0..2 idle cycles.
    // glitchIdx: the byte index at which start is pulsed again
    // (-1 = no extra pulse).
    task automatic applyStimulus(input int gapMode, input int glitchIdx);
        capQ.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start.busy", busy, 1);
        checkOutput("start.done", done, 0);
        checkOutput("start.err", err, 0);
        for (int i = 0; i < stimBytes.size(); i++) begin
            int gaps = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stimBytes[i];
            start    = (i == glitchIdx);
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic settleAndCheck(input string tag);
        int c = 0;
        while (busy === 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, ".idle"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, ".done"}, done, expDone);
        checkOutput({tag, ".err"}, err, expErr);
        checkOutput({tag, ".ready"}, in_ready, 0);
        checkOutput({tag, ".nwr"}, capQ.size(), expQ.size());
        for (int i = 0; i < capQ.size() && i < expQ.size(); i++) begin
            checkOutput({tag, ".waddr"}, capQ[i][63:32], expQ[i][63:32]);
            checkOutput({tag, ".wdata"}, capQ[i][31:0], expQ[i][31:0]);
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] n;
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Reset state (reset also wins over a simultaneous start).
        checkOutput("rst.in_ready", in_ready, 0);
        checkOutput("rst.we", we, 0);
        checkOutput("rst.waddr", waddr, 0);
        checkOutput("rst.wdata", wdata, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.err", err, 0);
        reset = 1'b0;

        // Bytes offered while idle are dropped.
        capQ.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("drop.busy", busy, 0);
        checkOutput("drop.nwr", capQ.size(), 0);

        // Directed two-word load.
        $display("[TB] directed load");
        buildDirected();
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("dir");

        // start in DONE opens a new session; start pulsed mid-DATA is ignored.
        $display("[TB] start during DATA");
        applyStimulus(0, 9);
        settleAndCheck("glitch");

        // in_valid toggling every other cycle.
        $display("[TB] gapped load");
        applyStimulus(1, -1);
        settleAndCheck("gap");

        // Bad word counts.
        stimBytes.delete();
        pushWord(32'h0000_0000);
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("len0");
        stimBytes.delete();
        pushWord(32'h0000_1001);
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("lenmax1");

`ifdef IM_LOADER_CKSUM_EN
        // Single zero word with a wrong checksum.
        stimBytes.delete();
        pushWord(32'h0000_0001);
        pushWord(32'h0000_0000);
        pushWord(32'h0000_0001);
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("badck");
`endif

        // Reset after the 2nd byte of word 1.
        $display("[TB] mid-session reset");
        buildDirected();
        capQ.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = stimBytes[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("abort.in_ready", in_ready, 0);
        checkOutput("abort.we", we, 0);
        checkOutput("abort.waddr", waddr, 0);
        checkOutput("abort.wdata", wdata, 0);
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.done", done, 0);
        checkOutput("abort.err", err, 0);
        repeat (5) @(negedge clk);
        checkOutput("abort.nwr", capQ.size(), 1);
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("fresh");

        // Largest legal count.
        $display("[TB] MAX_WORDS load");
        buildStream(32'(MAXW), s);
`ifdef IM_LOADER_CKSUM_EN
        pushWord(s);
`endif
        buildExpected();
        applyStimulus(0, -1);
        settleAndCheck("maxw");

        // Random sessions.
        $display("[TB] random sessions");
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 4) == 0)
                n = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(MAXW + 1 + int'($urandom_range(0, 5000)));
            else
                n = 32'($urandom_range(1, 6));
            buildStream(n, s);
`ifdef IM_LOADER_CKSUM_EN
            if (n != 32'd0 && n <= 32'(MAXW))
                pushWord(($urandom_range(0, 2) == 0) ? (s ^ (32'd1 << $urandom_range(0, 31))) : s);
`endif
            buildExpected();
            applyStimulus(2, -1);
            settleAndCheck("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_3000, byte address of instruction word 0.
REQ-002 Parameter: MAX_WORDS, 4096, largest accepted word count.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 in_data  input  8  byte from serial receiver.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte; transfer = in_valid & in_ready.
REQ-009 we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 waddr  output  32  byte address of the word being written.
REQ-011 wdata  output  32  assembled instruction word.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  session completed without error; sticky.
REQ-014 err  output  1  session aborted; sticky.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, CKSUM, DONE, ERR.
REQ-016 IDLE/DONE/ERR: start -> LEN, clear done, err, byte counter, word index, running sum; start in LEN/DATA/CKSUM SHALL be ignored.
REQ-017 in_ready SHALL be 1 exactly in LEN, DATA, CKSUM; busy SHALL equal in_ready.
REQ-018 Bytes SHALL be assembled big-endian: first transferred byte -> bits [31:24].
REQ-019 LEN: after 4 transfers the word is count N; N==0 or N>MAX_WORDS -> ERR, else -> DATA.
REQ-020 DATA: on the cycle after the 4th byte of word k, we=1, waddr=BASE_ADDR+4*k, wdata=word; waddr/wdata hold until next write.
REQ-021 Word index k SHALL run 0..N-1; after writing word N-1 -> CKSUM (macro defined) or DONE (macro undefined).
REQ-022 Running sum SHALL be the 32-bit modulo-2^32 sum of all N data words.
REQ-023 Byte transfers SHALL be accepted on consecutive cycles with no stall; gaps in in_valid SHALL not disturb the partial word.
REQ-024 Byte arriving while in_ready=0 SHALL be dropped with no state change.
REQ-025 DONE: done=1; ERR: err=1; each held until next start or reset; done and err never both 1.
REQ-026 we SHALL never assert outside DATA-completion cycles and never more than N times per session.

Reset
REQ-027 reset SHALL force IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, counters and sum zero.
REQ-028 reset mid-session SHALL abort immediately; no we after the reset cycle; reset dominates a simultaneous start.

Configuration
REQ-029 Macro IM_LOADER_CKSUM_EN defined: after the last word, CKSUM accepts 4 bytes; equal to running sum -> DONE, else -> ERR.
REQ-030 IM_LOADER_CKSUM_EN undefined: CKSUM state and sum logic absent; last word write -> DONE directly.

Verification
REQ-031 start; bytes 00 00 00 02, 24 08 00 01, 24 09 00 02 -> we at 0x3000=0x24080001, at 0x3004=0x24090002; checksum 48 11 00 03 (macro on) -> done=1.
REQ-032 start; length 00 00 00 00 -> err=1, no we; length 00 00 10 01 -> err=1.
REQ-033 Macro on: N=1, word 0x00000000, checksum 00 00 00 01 -> we once, then err=1, done=0.
REQ-034 N=2 with in_valid toggling every other cycle -> same writes/addresses as REQ-031.
REQ-035 reset asserted after 2nd byte of word 1 -> all outputs 0, no second write; fresh session loads correctly from 0x3000.
REQ-036 start pulsed during DATA -> ignored, index continues; start in DONE -> done cleared, new session.
